motor_pwm_mc: RTL and testbench
===============================

MOTOR_PWM_MC -- requirements
Module: motor_pwm_mc

Interface
REQ-001 SHALL have parameter CH, default 2: number of independent H-bridge motor channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 8: duty/PWM counter width in bits (3..12).
REQ-003 SHALL have parameter DEAD_CYC, default 16: bridge-off clocks inserted on a direction reversal (1..255).
REQ-004 SHALL have parameter RAMP_DIV, default 64: clocks per one-LSB duty ramp step (1..65535).
REQ-005 sclk  input  1  the single system clock; all logic is on its rising edge.
REQ-006 s_rst_n  input  1  reset, asynchronous and active-low.
REQ-007 enable  input  CH  per-channel run request; 1 = drive.
REQ-008 direct  input  CH  per-channel direction; 1 = forward, 0 = reverse.
REQ-009 duty  input  CH*CNT_W  per-channel target duty; channel i is bits [i*CNT_W +: CNT_W].
REQ-010 lim_f  input  CH  forward end-stop, active high, already synchronised and debounced.
REQ-011 lim_r  input  CH  reverse end-stop, active high, already synchronised and debounced.
REQ-012 MA  output  2*CH  bridge drive; channel i pair is {MA[2i+1], MA[2i]} = {A, B}; registered.
REQ-013 busy  output  CH  1 while channel i is not in IDLE; registered.

Function
REQ-014 One shared period counter pcnt SHALL count 0..2^CNT_W-2 and wrap to 0, giving a period of 2^CNT_W-1 clocks.
REQ-015 One shared ramp prescaler SHALL count 0..RAMP_DIV-1; ramp_tick = 1 for the one clock at RAMP_DIV-1, then wrap.
REQ-016 Each channel SHALL hold a CNT_W-bit current duty cur, a latched direction dir_q, a dead counter and a state from {IDLE, RUN, DEAD}.
REQ-017 pwm_on SHALL be (pcnt < cur): cur = 0 gives constant off; cur = 2^CNT_W-1 gives constant on.
REQ-018 Drive: RUN with dir_q = 1 gives MA pair {pwm_on, 0}; RUN with dir_q = 0 gives {0, pwm_on}; IDLE and DEAD give {0, 0}; {1, 1} SHALL never be driven.
REQ-019 MA SHALL be registered, so one clock of latency from pcnt/cur/state to pin.
REQ-020 The blocking end-stop is lim_f when the applicable direction is 1 and lim_r when it is 0.
REQ-021 IDLE->RUN when enable = 1 and the blocking end-stop for direct is 0; on entry dir_q <= direct and cur <= 0.
REQ-022 RUN->IDLE, with cur <= 0, when enable = 0 or the blocking end-stop for dir_q = 1; takes priority over REQ-023.
REQ-023 RUN->DEAD when direct != dir_q; on entry cur <= 0 and dead counter <= 0.
REQ-024 DEAD SHALL last exactly DEAD_CYC clocks.
REQ-025 DEAD->IDLE immediately if enable = 0.
REQ-026 At the end of DEAD, go to RUN with dir_q <= current direct if the blocking end-stop for that direction is 0, else go to IDLE.
REQ-027 In RUN, on ramp_tick, cur SHALL move one LSB toward the target duty (up or down) and hold when equal; the target may change at any time; no wrap or overshoot.
REQ-028 Channels SHALL be fully independent apart from the shared pcnt and ramp_tick; simultaneous events on different channels SHALL not interact.

Reset
REQ-029 While s_rst_n = 0: pcnt, prescaler, cur, dir_q and dead counters = 0; every state = IDLE; MA = 0; busy = 0.
REQ-030 After release, the first state change SHALL occur on the first rising sclk edge with s_rst_n = 1.
REQ-031 Reset asserted mid-RUN or mid-DEAD SHALL force MA = 0 asynchronously, without waiting for a clock edge.

Verification (CH=2, CNT_W=4, DEAD_CYC=4, RAMP_DIV=2)
REQ-032 Ramp: ch0 enable=1, direct=1, duty=15 -> cur steps 0..15 at one step per 2 clocks; then MA[1:0] = 2'b10 constant, MA[3:2] = 0, busy = 2'b01.
REQ-033 Duty: ch0 held at cur = 5 -> MA[1] = 1 for 5 of every 15 clocks, aligned to pcnt 0..4 plus one clock of latency; MA[0] = 0.
REQ-034 Reversal: ch0 at cur = 15, direct 1->0 -> MA[1:0] = 00 for exactly 4 clocks, then MA[0] ramps up from duty 0 and MA[1] stays 0.
REQ-035 End-stop: ch1 running reverse, lim_r[1] pulses 1 -> next clock state IDLE and MA[3:2] = 00; restart only after lim_r[1] = 0.
REQ-036 Edge cases: enable drop during DEAD -> IDLE, no RUN pulse; reset mid-RUN -> MA = 0 with no clock; ch0 and ch1 reversing in the same clock -> both see independent 4-clock dead windows; MA pair never 11 (assertion).

Source files
------------

// File: rtl/motor_pwm_mc.sv
// Multi-channel H-bridge PWM motor controller: shared period counter and ramp
// prescaler, and a per-channel ramped duty with dead time on direction reversal.

module motor_pwm_mc_ch #(
    parameter int CNT_W    = 8,
    parameter int DEAD_CYC = 16
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             ramp_tick,
    input  logic [CNT_W-1:0] pcnt,
    input  logic [CNT_W-1:0] target,
    input  logic             enable,
    input  logic             direct,
    input  logic             lim_f,
    input  logic             lim_r,
    output logic [1:0]       ma,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYC - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cur, cur_nx;
    logic             dir_q, dir_nx;
    logic [7:0]       dcnt, dcnt_nx;
    logic             blk_dir, blk_q, pwm_on;

    // End-stop that blocks the requested direction vs. the latched one
    assign blk_dir = direct ? lim_f : lim_r;
    assign blk_q   = dir_q  ? lim_f : lim_r;
    assign pwm_on  = (pcnt < cur);

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        dir_nx   = dir_q;
        dcnt_nx  = dcnt;
        unique case (state)
            IDLE: if (enable && !blk_dir) begin
                state_nx = RUN;
                dir_nx   = direct;
                cur_nx   = '0;
            end
            RUN: if (!enable || blk_q) begin
                state_nx = IDLE;
                cur_nx   = '0;
            end else if (direct != dir_q) begin
                state_nx = DEAD;
                cur_nx   = '0;
                dcnt_nx  = '0;
            end else if (ramp_tick) begin
                if (cur < target)      cur_nx = cur + CNT_W'(1);
                else if (cur > target) cur_nx = cur - CNT_W'(1);
            end
            DEAD: if (!enable) begin
                state_nx = IDLE;
            end else if (dcnt == DEAD_LAST) begin
                if (!blk_dir) begin
                    state_nx = RUN;
                    dir_nx   = direct;
                end else begin
                    state_nx = IDLE;
                end
            end else begin
                dcnt_nx = dcnt + 8'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state <= IDLE;
            cur   <= '0;
            dir_q <= 1'b0;
            dcnt  <= '0;
            ma    <= 2'b00;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cur   <= cur_nx;
            dir_q <= dir_nx;
            dcnt  <= dcnt_nx;
            // Only one leg can ever carry pwm_on, so 2'b11 is unreachable
            ma    <= (state == RUN) ? (dir_q ? {pwm_on, 1'b0} : {1'b0, pwm_on}) : 2'b00;
            busy  <= (state_nx != IDLE);
        end
    end
endmodule

module motor_pwm_mc #(
    parameter int CH       = 2,
    parameter int CNT_W    = 8,
    parameter int DEAD_CYC = 16,
    parameter int RAMP_DIV = 64
) (
    input  logic                sclk,
    input  logic                s_rst_n,
    input  logic [CH-1:0]       enable,
    input  logic [CH-1:0]       direct,
    input  logic [CH*CNT_W-1:0] duty,
    input  logic [CH-1:0]       lim_f,
    input  logic [CH-1:0]       lim_r,
    output logic [2*CH-1:0]     MA,
    output logic [CH-1:0]       busy
);
    // Period is 2^CNT_W-1 so a full-scale duty is a constant-on output
    localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'((1 << CNT_W) - 2);
    localparam logic [15:0]      PRE_LAST  = 16'(RAMP_DIV - 1);

    logic [CNT_W-1:0] pcnt;
    logic [15:0]      pre;
    logic             ramp_tick;

    assign ramp_tick = (pre == PRE_LAST);

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            pcnt <= '0;
            pre  <= '0;
        end else begin
            pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + CNT_W'(1);
            pre  <= ramp_tick ? '0 : pre + 16'd1;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        motor_pwm_mc_ch #(.CNT_W(CNT_W), .DEAD_CYC(DEAD_CYC)) u_ch (
            .sclk      (sclk),
            .s_rst_n   (s_rst_n),
            .ramp_tick (ramp_tick),
            .pcnt      (pcnt),
            .target    (duty[i*CNT_W +: CNT_W]),
            .enable    (enable[i]),
            .direct    (direct[i]),
            .lim_f     (lim_f[i]),
            .lim_r     (lim_r[i]),
            .ma        (MA[2*i +: 2]),
            .busy      (busy[i])
        );
    end
endmodule

// File: tb/tb_motor_pwm_mc.sv
// Bench for motor_pwm_mc: directed scenarios plus random traffic, all compared
// against a clock-by-clock behavioural model of the channel rules.

module tb_motor_pwm_mc;
    localparam int CH   = 2;
    localparam int CW   = 4;
    localparam int DCYC = 4;
    localparam int RDIV = 2;
    localparam int PER  = (1 << CW) - 1;
    localparam int S_IDLE = 0, S_RUN = 1, S_DEAD = 2;

    logic              sclk = 1'b0;
    logic              s_rst_n = 1'b0;
    logic [CH-1:0]     enable = '0, direct = '0, lim_f = '0, lim_r = '0;
    logic [CH*CW-1:0]  duty = '0;
    logic [2*CH-1:0]   MA;
    logic [CH-1:0]     busy;

    int checks = 0;
    int errors = 0;

    // Behavioural model: time since reset, per-channel state/duty/direction
    int              m_t;
    int              m_st[CH];
    int              m_cur[CH];
    bit              m_dir[CH];
    int              m_dleft[CH];
    logic [2*CH-1:0] m_ma;
    logic [CH-1:0]   m_busy;

    motor_pwm_mc #(.CH(CH), .CNT_W(CW), .DEAD_CYC(DCYC), .RAMP_DIV(RDIV)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .enable(enable), .direct(direct),
        .duty(duty), .lim_f(lim_f), .lim_r(lim_r), .MA(MA), .busy(busy)
    );

    always #5 sclk = ~sclk;

    task automatic model_reset();
        m_t = 0;
        m_ma = '0;
        m_busy = '0;
        for (int i = 0; i < CH; i++) begin
            m_st[i] = S_IDLE; m_cur[i] = 0; m_dir[i] = 0; m_dleft[i] = 0;
        end
    endtask

    task automatic model_edge();
        int pc, tgt;
        bit tick, blk_d, blk_q, on;
        pc   = m_t % PER;
        tick = (m_t % RDIV) == RDIV - 1;
        for (int i = 0; i < CH; i++) begin
            tgt   = int'(duty[i*CW +: CW]);
            blk_d = direct[i] ? lim_f[i] : lim_r[i];
            blk_q = m_dir[i]  ? lim_f[i] : lim_r[i];
            on    = pc < m_cur[i];
            m_ma[2*i +: 2] = (m_st[i] != S_RUN) ? 2'b00 : (m_dir[i] ? {on, 1'b0} : {1'b0, on});
            case (m_st[i])
                S_IDLE: if (enable[i] && !blk_d) begin
                    m_st[i] = S_RUN; m_dir[i] = direct[i]; m_cur[i] = 0;
                end
                S_RUN: if (!enable[i] || blk_q) begin
                    m_st[i] = S_IDLE; m_cur[i] = 0;
                end else if (direct[i] != m_dir[i]) begin
                    m_st[i] = S_DEAD; m_cur[i] = 0; m_dleft[i] = DCYC;
                end else if (tick && m_cur[i] != tgt) begin
                    m_cur[i] += (tgt > m_cur[i]) ? 1 : -1;
                end
                default: if (!enable[i]) begin
                    m_st[i] = S_IDLE;
                end else begin
                    m_dleft[i]--;
                    if (m_dleft[i] == 0) begin
                        if (!blk_d) begin m_st[i] = S_RUN; m_dir[i] = direct[i]; end
                        else m_st[i] = S_IDLE;
                    end
                end
            endcase
            m_busy[i] = (m_st[i] != S_IDLE);
        end
        m_t++;
    endtask

    task automatic step();
        model_edge();
        @(posedge sclk);
        #1;
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0;
        enable = '1; direct = '1; duty = '1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge sclk); #1;
            checks++;
            if (MA !== '0 || busy !== '0) begin
                errors++;
                $display("FAIL reset cyc=%0d MA=%b busy=%b expected 0", c, MA, busy);
            end
        end
        enable = '0; direct = '0; duty = '0;
        #2 s_rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        enable[0] = 1'b1; direct[0] = 1'b1; duty[0 +: CW] = 4'd15;
        for (int c = 0; c < 40; c++) begin
            step();
            checks++;
            if (MA !== m_ma || busy !== m_busy) begin
                errors++;
                $display("FAIL ramp cyc=%0d MA=%b busy=%b model MA=%b busy=%b", c, MA, busy, m_ma, m_busy);
            end
        end
        for (int c = 0; c < PER; c++) begin
            step();
            checks++;
            if (MA !== 4'b0010 || busy !== 2'b01) begin
                errors++;
                $display("FAIL ramp_full cyc=%0d MA=%b busy=%b expected MA=0010 busy=01", c, MA, busy);
            end
        end
    endtask

    task automatic test_duty();
        int ones;
        duty[0 +: CW] = 4'd5;
        for (int c = 0; c < 25; c++) begin
            step();
            checks++;
            if (MA !== m_ma || busy !== m_busy) begin
                errors++;
                $display("FAIL duty cyc=%0d MA=%b busy=%b model MA=%b busy=%b", c, MA, busy, m_ma, m_busy);
            end
        end
        ones = 0;
        for (int c = 0; c < PER; c++) begin
            step();
            if (MA[1]) ones++;
            checks++;
            if (MA[0] !== 1'b0 || MA !== m_ma) begin
                errors++;
                $display("FAIL duty_win cyc=%0d MA=%b model MA=%b", c, MA, m_ma);
            end
        end
        checks++;
        if (ones != 5) begin
            errors++;
            $display("FAIL duty_count high=%0d expected 5", ones);
        end
    endtask

    task automatic test_reversal();
        bit saw_b;
        duty[0 +: CW] = 4'd15;
        for (int c = 0; c < 25; c++) step();
        direct[0] = 1'b0;
        step();
        checks++;
        if (MA[1:0] !== 2'b10) begin
            errors++;
            $display("FAIL rev_last_run MA=%b expected 10", MA[1:0]);
        end
        for (int c = 0; c < DCYC; c++) begin
            step();
            checks++;
            if (MA[1:0] !== 2'b00 || busy[0] !== 1'b1 || MA !== m_ma) begin
                errors++;
                $display("FAIL rev_dead cyc=%0d MA=%b busy=%b expected pair 00 busy 1", c, MA, busy);
            end
        end
        saw_b = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (MA[0]) saw_b = 1;
            checks++;
            if (MA[1] !== 1'b0 || MA !== m_ma || busy !== m_busy) begin
                errors++;
                $display("FAIL rev_run cyc=%0d MA=%b busy=%b model MA=%b busy=%b", c, MA, busy, m_ma, m_busy);
            end
        end
        checks++;
        if (!saw_b) begin
            errors++;
            $display("FAIL rev_ramp MA[0] never high, expected ramp in reverse");
        end
    endtask

    task automatic test_endstop();
        enable[1] = 1'b1; direct[1] = 1'b0; duty[CW +: CW] = 4'd10;
        for (int c = 0; c < 20; c++) step();
        lim_r[1] = 1'b1;
        step();
        checks++;
        if (busy[1] !== 1'b0 || busy !== m_busy) begin
            errors++;
            $display("FAIL endstop_stop busy=%b expected ch1 idle (model %b)", busy, m_busy);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (MA[3:2] !== 2'b00 || busy[1] !== 1'b0 || MA !== m_ma) begin
                errors++;
                $display("FAIL endstop_hold cyc=%0d MA=%b busy=%b expected ch1 off", c, MA, busy);
            end
        end
        lim_r[1] = 1'b0;
        step();
        checks++;
        if (busy[1] !== 1'b1 || busy !== m_busy) begin
            errors++;
            $display("FAIL endstop_restart busy=%b expected ch1 running", busy);
        end
    endtask

    task automatic test_dead_enable_drop();
        direct[0] = 1'b1;
        step();
        step();
        enable[0] = 1'b0;
        step();
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL dead_drop busy=%b expected ch0 idle", busy);
        end
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (MA[1:0] !== 2'b00 || MA !== m_ma || busy !== m_busy) begin
                errors++;
                $display("FAIL dead_drop_pulse cyc=%0d MA=%b busy=%b model MA=%b", c, MA, busy, m_ma);
            end
        end
    endtask

    task automatic test_simul_reverse();
        enable = 2'b11; direct = 2'b11; duty = {4'd9, 4'd12};
        for (int c = 0; c < 30; c++) step();
        direct = 2'b00;
        step();
        for (int c = 0; c < DCYC; c++) begin
            step();
            checks++;
            if (MA !== 4'b0000 || busy !== 2'b11) begin
                errors++;
                $display("FAIL simul_dead cyc=%0d MA=%b busy=%b expected 0000/11", c, MA, busy);
            end
        end
        for (int c = 0; c < 30; c++) begin
            step();
            checks++;
            if (MA !== m_ma || busy !== m_busy) begin
                errors++;
                $display("FAIL simul_run cyc=%0d MA=%b busy=%b model MA=%b busy=%b", c, MA, busy, m_ma, m_busy);
            end
        end
    endtask

    task automatic test_async_reset();
        int guard;
        guard = 0;
        while (MA === '0 && guard < 2 * PER) begin
            step();
            guard++;
        end
        checks++;
        if (MA === '0) begin
            errors++;
            $display("FAIL async_setup MA=%b expected some drive before reset", MA);
        end
        #2 s_rst_n = 1'b0;
        #1;
        checks++;
        if (MA !== '0 || busy !== '0) begin
            errors++;
            $display("FAIL async_reset MA=%b busy=%b expected 0 with no clock", MA, busy);
        end
        model_reset();
        #2 s_rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (MA !== m_ma || busy !== m_busy) begin
                errors++;
                $display("FAIL post_reset cyc=%0d MA=%b busy=%b model MA=%b busy=%b", c, MA, busy, m_ma, m_busy);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(19) == 0) enable[i] = ~enable[i];
                if ($urandom_range(24) == 0) direct[i] = ~direct[i];
                if ($urandom_range(29) == 0) duty[i*CW +: CW] = CW'($urandom_range(PER));
                if ($urandom_range(39) == 0) lim_f[i] = 1'b1;
                else if ($urandom_range(7) == 0) lim_f[i] = 1'b0;
                if ($urandom_range(39) == 0) lim_r[i] = 1'b1;
                else if ($urandom_range(7) == 0) lim_r[i] = 1'b0;
            end
            step();
            checks++;
            if (MA !== m_ma || busy !== m_busy) begin
                errors++;
                $display("FAIL random cyc=%0d MA=%b busy=%b model MA=%b busy=%b", c, MA, busy, m_ma, m_busy);
            end
            for (int i = 0; i < CH; i++) begin
                checks++;
                if (MA[2*i +: 2] === 2'b11) begin
                    errors++;
                    $display("FAIL shoot_through cyc=%0d ch=%0d MA=%b", c, i, MA);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_duty();
        test_reversal();
        test_endstop();
        test_dead_enable_drop();
        test_simul_reverse();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
